io_burst_sequencer: RTL and testbench

// - Shares the bit-addressed IO memory port (1 bit per access, dataIn[0] / dataOut[0])

---
 rtl/io_burst_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_io_burst_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_burst_sequencer.sv
// Serialises word-wide read/write requests from two requesters into bursts of
// single-bit IO memory accesses at consecutive addresses, with alternating tie arbitration.
module io_burst_sequencer #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              io_en,
    output logic [ADDR_W-1:0] io_address,
    output logic [DATA_W-1:0] io_dataIn,
    input  logic [DATA_W-1:0] io_dataOut
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              io_en_q, io_en_d;
    logic              io_bit_q, io_bit_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;

    logic              pick1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [LEN_W-1:0]  sel_len_clamped;
    logic [DATA_W-1:0] sel_wdata;
    logic              last_beat;

    // Only bit 0 of the IO read data carries information.
    logic unused_dataout;
    assign unused_dataout = ^io_dataOut[DATA_W-1:1];

    always_comb begin
        pick1     = req1 & (~req0 | ~last_grant_q);
        sel_we    = pick1 ? we1    : we0;
        sel_addr  = pick1 ? addr1  : addr0;
        sel_len   = pick1 ? len1   : len0;
        sel_wdata = pick1 ? wdata1 : wdata0;
        if (sel_len == '0) begin
            sel_len_clamped = ONE_LEN;
        end else if (sel_len > MAX_LEN) begin
            sel_len_clamped = MAX_LEN;
        end else begin
            sel_len_clamped = sel_len;
        end
        last_beat = (cnt_q == (len_q - ONE_LEN));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;
        io_en_d      = io_en_q;
        io_bit_d     = io_bit_q;
        io_addr_d    = io_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d      = S_XFER;
                    gnt_d        = pick1;
                    last_grant_d = pick1;
                    we_d         = sel_we;
                    len_d        = sel_len_clamped;
                    wdata_d      = sel_wdata;
                    cnt_d        = '0;
                    rbuf_d       = '0;
                    busy_d       = 1'b1;
                    // IO outputs are registered one beat ahead so they change only on posedge.
                    io_en_d      = sel_we;
                    io_addr_d    = sel_addr;
                    io_bit_d     = sel_wdata[0];
                end
            end
            S_XFER: begin
                if (!we_q) begin
                    rbuf_d[cnt_q] = io_dataOut[0];
                end
                if (last_beat) begin
                    state_d   = S_DONE;
                    io_en_d   = 1'b0;
                    io_bit_d  = 1'b0;
                    io_addr_d = '0;
                    ack0_d    = ~gnt_q;
                    ack1_d    = gnt_q;
                    rdata_d   = rbuf_d;
                end else begin
                    cnt_d     = cnt_q + ONE_LEN;
                    io_addr_d = io_addr_q + ADDR_W'(1);
                    io_bit_d  = wdata_q[cnt_d];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            io_en_q      <= 1'b0;
            io_bit_q     <= 1'b0;
            io_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            io_en_q      <= io_en_d;
            io_bit_q     <= io_bit_d;
            io_addr_q    <= io_addr_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign io_en      = io_en_q;
    assign io_address = io_addr_q;
    assign io_dataIn  = {{(DATA_W-1){1'b0}}, io_bit_q};
endmodule

// File: tb/tb_io_burst_sequencer.sv
// Self-checking bench for io_burst_sequencer: a bit-wide IO memory model, directed
// vectors, arbitration/reset sequences and random bursts against a shadow-memory model.
module tb_io_burst_sequencer;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [LEN_W-1:0]  len0 = '0, len1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, busy, io_en;
    logic [DATA_W-1:0] rdata, io_dataIn, io_dataOut;
    logic [ADDR_W-1:0] io_address;

    bit                tb_mem  [256];
    bit                ref_mem [256];
    logic              pl_en = 1'b0;
    logic [7:0]        pl_addr = '0;
    logic              pl_bit = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [4:0]  len;
        logic [23:0] wdata;
        logic [23:0] exp_rdata;
    } vec_t;
    vec_t vecs [9];

    io_burst_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .io_en(io_en), .io_address(io_address), .io_dataIn(io_dataIn),
        .io_dataOut(io_dataOut)
    );

    always #5 clk = ~clk;

    // IO memory: writes on negedge, combinational read of bit 0.
    always @(negedge clk) begin
        if (io_en) tb_mem[io_address] <= io_dataIn[0];
        else if (pl_en) tb_mem[pl_addr] <= pl_bit;
    end
    assign io_dataOut = {{(DATA_W-1){1'b0}}, tb_mem[io_address]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        return (l == 0) ? 1 : ((l > DATA_W) ? DATA_W : l);
    endfunction

    task automatic preload(input logic [7:0] a, input bit b);
        pl_addr = a;
        pl_bit  = b;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[a] = b;
    endtask

    task automatic run_burst(input bit port, input bit we, input logic [7:0] addr,
                             input logic [4:0] len, input logic [23:0] wdata,
                             input logic [23:0] exp_rdata, input string tag);
        int L;
        bit got;
        logic [7:0] a;
        L = clamp_len(int'(len));
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; len1 = len; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; len0 = len; wdata0 = wdata;
        end
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_grant"}, 32'(got), 32'd1);
        if (!got) begin
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        // Command fields must already be latched: scramble them.
        if (port) begin
            we1 = 1'($urandom); addr1 = 8'($urandom); len1 = 5'($urandom); wdata1 = 24'($urandom);
        end else begin
            we0 = 1'($urandom); addr0 = 8'($urandom); len0 = 5'($urandom); wdata0 = 24'($urandom);
        end
        for (int k = 0; k < L; k++) begin
            a = addr + 8'(k);
            chk({tag, "_io_en"}, 32'(io_en), 32'(we));
            chk({tag, "_io_address"}, 32'(io_address), 32'(a));
            chk({tag, "_io_dataIn"}, 32'(io_dataIn), 32'(wdata[k]));
            chk({tag, "_ack_early"}, 32'({ack1, ack0}), 32'd0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_ack"}, 32'({ack1, ack0}), port ? 32'd2 : 32'd1);
        chk({tag, "_done_io_en"}, 32'(io_en), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 32'({busy, ack1, ack0}), 32'd0);
        if (we) begin
            for (int k = 0; k < L; k++) ref_mem[addr + 8'(k)] = wdata[k];
        end
        $display("txn %s port=%0d we=%0d addr=%0d len=%0d beats=%0d rdata=%06h",
                 tag, port, we, addr, len, L, rdata);
    endtask

    initial begin
        int nack;
        int order [4];
        int cnt;
        bit got;
        logic [7:0] abort_bits;

        vecs[0] = '{1'b0, 1'b1, 8'd4,   5'd3,  24'h000005, 24'h000000};
        vecs[1] = '{1'b1, 1'b0, 8'd72,  5'd4,  24'h000000, 24'h00000A};
        vecs[2] = '{1'b0, 1'b1, 8'd100, 5'd0,  24'hFFFFFF, 24'h000000};
        vecs[3] = '{1'b1, 1'b0, 8'd100, 5'd1,  24'h000000, 24'h000001};
        vecs[4] = '{1'b0, 1'b1, 8'd200, 5'd31, 24'hA5C3F1, 24'h000000};
        vecs[5] = '{1'b1, 1'b0, 8'd200, 5'd31, 24'h000000, 24'hA5C3F1};
        vecs[6] = '{1'b0, 1'b1, 8'd254, 5'd3,  24'h000006, 24'h000000};
        vecs[7] = '{1'b1, 1'b0, 8'd254, 5'd3,  24'h000000, 24'h000006};
        vecs[8] = '{1'b0, 1'b0, 8'd4,   5'd3,  24'h000000, 24'h000005};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({ack0, ack1, busy, io_en}), 32'd0);
        chk("reset_addr", 32'(io_address), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Ties from reset: req0 first, then alternating.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        len0 = 5'd1; len1 = 5'd1; addr0 = 8'd10; addr1 = 8'd11;
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(posedge clk);
            #1;
            chk("tie_exclusive_ack", 32'(ack0 & ack1), 32'd0);
            if (ack0 | ack1) begin
                order[nack] = int'(ack1);
                nack++;
                if (nack == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        chk("tie_ack_count", 32'(nack), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));
        repeat (2) @(posedge clk);
        #1;
        $display("txn tie acks=%0d order=%0d%0d%0d%0d", nack, order[0], order[1], order[2], order[3]);

        // Switch inputs at 72..75 = 4'b1010
        preload(8'd72, 1'b0);
        preload(8'd73, 1'b1);
        preload(8'd74, 1'b0);
        preload(8'd75, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].len,
                      vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end
        chk("gpio_bits_6_4", 32'({tb_mem[6], tb_mem[5], tb_mem[4]}), 32'b101);
        chk("wrap_bits", 32'({tb_mem[0], tb_mem[255], tb_mem[254]}), 32'b110);

        // Reset in the 2nd XFER cycle of a len=8 write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'd40; len0 = 5'd8; wdata0 = 24'h0000FF;
        got = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_grant", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ctrl_zero", 32'({ack0, ack1, busy, io_en}), 32'd0);
        chk("abort_addr_zero", 32'(io_address), 32'd0);
        chk("abort_data_zero", 32'(io_dataIn), 32'd0);
        chk("abort_rdata_zero", 32'(rdata), 32'd0);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (ack0 | ack1 | busy) cnt++;
        end
        chk("abort_no_ack", 32'(cnt), 32'd0);
        for (int i = 0; i < 8; i++) abort_bits[i] = tb_mem[40 + i];
        chk("abort_mem", 32'(abort_bits), 32'h01);
        ref_mem[40] = 1'b1;
        $display("txn abort addr=40 len=8 mem=%02h", abort_bits);
        run_burst(1'b1, 1'b0, 8'd40, 5'd8, 24'h0, 24'h000001, "after_abort");

        // Random bursts against the shadow memory.
        for (int t = 0; t < 40; t++) begin
            bit p, w;
            logic [7:0] a;
            logic [4:0] l;
            logic [23:0] d, e;
            int L;
            p = 1'($urandom);
            w = 1'($urandom);
            a = 8'($urandom);
            l = 5'($urandom_range(0, 31));
            d = 24'($urandom);
            L = clamp_len(int'(l));
            e = '0;
            if (!w) begin
                for (int k = 0; k < L; k++) e[k] = ref_mem[a + 8'(k)];
            end
            run_burst(p, w, a, l, d, e, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
